// File: rtl/fft_sample_framer.sv
// fft_sample_framer
//   Collects strobed microphone samples into FRAME_LEN-long frames using two
//   ping-pong banks and streams each completed frame to the FFT over a
//   valid/ready interface tagged with start/end-of-frame and sample index.
//   Samples arriving while the bank being filled is still waiting to be read
//   are dropped and flagged on the sticky overflow output.
//
//   Optional feature: define FFT_FRAMER_DC_REMOVE_EN to subtract a running
//   DC estimate (leaky integrator, time constant 256 samples) from every
//   stored sample, saturated to the DATA_W signed range.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous active-high reset
//   new_t      one-cycle strobe, t carries a valid sample
//   t          signed input sample
//   out_data   signed frame sample (bank[rd_bank][rd_idx])
//   out_valid  out_data valid
//   out_ready  FFT accepts the current sample
//   out_sop    first sample of a frame
//   out_eop    last sample of a frame
//   out_index  position of out_data within the frame
//   overflow   sticky flag, a sample was dropped
module fft_sample_framer #(
    parameter int FRAME_LEN = 64,
    parameter int DATA_W    = 18,
    localparam int IDX_W    = $clog2(FRAME_LEN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_t,
    input  logic signed [DATA_W-1:0] t,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [IDX_W-1:0]         out_index,
    output logic                     overflow
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic signed [DATA_W-1:0] mem [2][FRAME_LEN];

    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;
    logic [0:0]       state;

    logic wr_en;
    logic wr_last;
    logic rd_xfer;
    logic rd_last;

    logic signed [DATA_W-1:0] wr_val;

`ifdef FFT_FRAMER_DC_REMOVE_EN
    localparam int ACC_W = DATA_W + 8;

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [DATA_W:0] v);
        // The two top bits disagree only when the difference left the DATA_W range.
        if (v[DATA_W] != v[DATA_W-1])
            return v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            return v[DATA_W-1:0];
    endfunction

    logic signed [ACC_W-1:0]  dc_acc;
    logic signed [ACC_W-1:0]  dc_est;
    logic signed [DATA_W:0]   dc_diff;

    // dc_acc settles near 256 * mean(t), so dc_est always fits the sample range.
    assign dc_est  = dc_acc >>> 8;
    assign dc_diff = (DATA_W+1)'(t) - (DATA_W+1)'(dc_est);
    assign wr_val  = sat_data(dc_diff);

    // The estimate tracks every strobe, including dropped samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dc_acc <= '0;
        else if (new_t)
            dc_acc <= dc_acc + ACC_W'(t) - dc_est;
    end
`else
    assign wr_val = t;
`endif

    assign wr_en   = new_t && !full[wr_bank];
    assign wr_last = wr_en && (wr_idx == LAST_IDX);
    assign rd_xfer = (state == ST_STREAM) && out_ready;
    assign rd_last = rd_xfer && (rd_idx == LAST_IDX);

    // A bank being read is full and thus never written, so the clear and the
    // set always hit different banks and both survive on a shared edge.
    always_comb begin
        full_nxt = full;
        if (rd_last)
            full_nxt[rd_bank] = 1'b0;
        if (wr_last)
            full_nxt[wr_bank] = 1'b1;
    end

    // Sample storage carries no reset; pending frames are discarded by the flags.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_bank][wr_idx] <= wr_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            wr_idx   <= '0;
            rd_bank  <= 1'b0;
            rd_idx   <= '0;
            state    <= ST_IDLE;
            overflow <= 1'b0;
        end else begin
            full <= full_nxt;

            // Drop decision uses the flag before this edge, even if it is being cleared now.
            if (new_t && full[wr_bank])
                overflow <= 1'b1;

            if (wr_en) begin
                if (wr_last) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (full[rd_bank])
                        state <= ST_STREAM;
                end
                default: begin
                    if (rd_xfer) begin
                        if (rd_last) begin
                            rd_idx  <= '0;
                            rd_bank <= ~rd_bank;
                            state   <= ST_IDLE;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid = (state == ST_STREAM);
    assign out_data  = mem[rd_bank][rd_idx];
    assign out_index = rd_idx;
    assign out_sop   = out_valid && (rd_idx == '0);
    assign out_eop   = out_valid && (rd_idx == LAST_IDX);

endmodule

// File: tb/tb_fft_sample_framer.sv
// Testbench for fft_sample_framer with FRAME_LEN=8, DATA_W=18.
module tb_fft_sample_framer;

    localparam int FL = 8;
    localparam int DW = 18;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 new_t;
    logic signed [DW-1:0] t;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sop;
    logic                 out_eop;
    logic [2:0]           out_index;
    logic                 overflow;

    int   checks = 0;
    int   errors = 0;
    logic exp_ovf = 1'b0;

    typedef struct {
        logic nt;
        int   tv;
        logic rdy;
        logic ev;
        int   ed;
        int   ei;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    fft_sample_framer #(.FRAME_LEN(FL), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .new_t     (new_t),
        .t         (t),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_index (out_index),
        .overflow  (overflow)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ev, input int ed, input int ei);
        chk({tag, " valid"}, out_valid, int'(ev));
        chk({tag, " overflow"}, overflow, int'(exp_ovf));
        if (ev) begin
            chk({tag, " data"}, out_data, ed);
            chk({tag, " index"}, out_index, ei);
            chk({tag, " sop"}, out_sop, int'(ei == 0));
            chk({tag, " eop"}, out_eop, int'(ei == FL - 1));
        end else begin
            chk({tag, " sop"}, out_sop, 0);
            chk({tag, " eop"}, out_eop, 0);
        end
    endtask

    task automatic push(input int v);
        new_t = 1'b1;
        t     = DW'(v);
        tick();
        new_t = 1'b0;
    endtask

    // Reads one whole frame with out_ready high; optionally strobes a sample
    // on the same edge as the eop transfer.
    task automatic drain_frame(input string tag, input int base, input bit push_on_eop, input int pv);
        out_ready = 1'b1;
        for (int i = 0; i < FL; i++) begin
            check_out($sformatf("%s[%0d]", tag, i), 1'b1, base + i, i);
            if (i == FL - 1 && push_on_eop) begin
                new_t = 1'b1;
                t     = DW'(pv);
            end
            tick();
            new_t = 1'b0;
        end
        check_out({tag, " after eop"}, 1'b0, 0, 0);
    endtask

    initial begin
        // First frame: 8 strobes then a streamed frame with out_ready high.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{nt: 1'b1, tv: i + 1, rdy: 1'b1, ev: 1'b0, ed: 0, ei: 0};
        for (int i = 8; i < 16; i++)
            vecs[i] = '{nt: 1'b0, tv: 0, rdy: 1'b1, ev: 1'b1, ed: i - 7, ei: i - 8};
        vecs[16] = '{nt: 1'b0, tv: 0, rdy: 1'b1, ev: 1'b0, ed: 0, ei: 0};

        reset     = 1'b1;
        new_t     = 1'b0;
        t         = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 0, 0);
        chk("reset index", out_index, 0);
        reset = 1'b0;
        tick();

`ifndef FFT_FRAMER_DC_REMOVE_EN
        for (int r = 0; r < 17; r++) begin
            new_t     = vecs[r].nt;
            t         = DW'(vecs[r].tv);
            out_ready = vecs[r].rdy;
            tick();
            check_out($sformatf("vec%0d", r), vecs[r].ev, vecs[r].ed, vecs[r].ei);
        end
        new_t = 1'b0;

        // Backpressure: hold at index 3 for 20 cycles, then resume.
        out_ready = 1'b0;
        for (int i = 0; i < FL; i++)
            push(101 + i);
        check_out("stall pre", 1'b0, 0, 0);
        tick();
        check_out("stall s0", 1'b1, 101, 0);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            check_out($sformatf("stall s%0d", i), 1'b1, 101 + i, i);
        end
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_out($sformatf("stall hold%0d", c), 1'b1, 104, 3);
        end
        out_ready = 1'b1;
        for (int i = 4; i < FL; i++) begin
            tick();
            check_out($sformatf("stall s%0d", i), 1'b1, 101 + i, i);
        end
        tick();
        check_out("stall end", 1'b0, 0, 0);

        // Overflow: both banks fill, the 17th sample is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push(201 + i);
            chk($sformatf("ovf after push%0d", i), overflow, int'(i == 16));
        end
        exp_ovf = 1'b1;
        tick();
        // A sample arriving on the edge that frees bank0 must still be dropped.
        drain_frame("ovf f0", 201, 1'b1, 999);
        tick();
        drain_frame("ovf f1", 209, 1'b0, 0);

        // Next frame lands in bank0 starting with 701, not 999.
        for (int i = 0; i < FL; i++)
            push(701 + i);
        check_out("post drop pre", 1'b0, 0, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check_out($sformatf("post drop s%0d", i), 1'b1, 701 + i, i);
            if (i < 5)
                tick();
        end

        // Asynchronous reset mid-stream at index 5.
        reset   = 1'b1;
        exp_ovf = 1'b0;
        #1;
        check_out("midreset", 1'b0, 0, 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < FL; i++)
            push(401 + i);
        check_out("fresh pre", 1'b0, 0, 0);
        tick();
        drain_frame("fresh", 401, 1'b0, 0);

        // bank1 eop transfer coincides with the 8th write into bank0.
        out_ready = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            if (c <= 8) begin
                new_t = 1'b1;
                t     = DW'(500 + c);
            end else if (c >= 10) begin
                new_t = 1'b1;
                t     = DW'(600 + c - 9);
            end else begin
                new_t = 1'b0;
            end
            tick();
            new_t = 1'b0;
            if (c >= 9 && c <= 16)
                check_out($sformatf("same edge c%0d", c), 1'b1, 501 + c - 9, c - 9);
            else
                check_out($sformatf("same edge c%0d", c), 1'b0, 0, 0);
        end
        tick();
        drain_frame("same edge next", 601, 1'b0, 0);
`else
        begin
            int prev;
            int got;
            int last8 [FL];
            prev      = 32'h7fffffff;
            got       = 0;
            out_ready = 1'b1;
            for (int n = 0; n < 8192 + 40; n++) begin
                new_t = (n < 8192) && (n % 2 == 0);
                t     = DW'(1000);
                tick();
                new_t = 1'b0;
                if (out_valid) begin
                    if (got == 0)
                        chk("dc first", out_data, 1000);
                    chk($sformatf("dc mono%0d", got), int'(int'(out_data) <= prev), 1);
                    prev           = int'(out_data);
                    last8[got % FL] = int'(out_data);
                    got++;
                end
            end
            chk("dc count", got, 4096);
            chk("dc overflow", overflow, 0);
            for (int i = 0; i < FL; i++)
                chk($sformatf("dc final%0d", i), int'(last8[i] >= -4 && last8[i] <= 4), 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
